// File: rtl/pcs_rx_block_lock.sv
// 64b/66b RX block-lock stage: hunts for sync-header alignment, pulses the gearbox slip,
// and forwards the gearbox word/header downstream through one register stage.
module pcs_rx_block_lock #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned SH_CNT_MAX       = 64,
    parameter int unsigned SH_INVLD_MAX     = 16,
    parameter int unsigned SLIP_WAIT_CYCLES = 32
) (
    input  logic                  gty_rx_usr_clk,
    input  logic                  gty_rx_usr_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_data_valid,
    input  logic [1:0]            i_rx_header,
    input  logic                  i_rx_header_valid,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_data_valid,
    output logic [1:0]            o_rx_header,
    output logic                  o_rx_header_valid,
    output logic                  o_rx_gearbox_slip,
    output logic                  o_block_lock
);

    localparam int unsigned ShCntW = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned InvldW = $clog2(SH_INVLD_MAX + 1);
    localparam int unsigned WaitW  = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [ShCntW-1:0] ShCntMax = ShCntW'(SH_CNT_MAX);
    localparam logic [InvldW-1:0] InvldMax = InvldW'(SH_INVLD_MAX);
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(SLIP_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StResetCnt,
        StTestSh,
        StSlipWait
    } state_e;

    state_e                state_q, state_d;
    logic [ShCntW-1:0]     sh_cnt_q, sh_cnt_d;
    logic [InvldW-1:0]     sh_invld_cnt_q, sh_invld_cnt_d;
    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  block_lock_q, block_lock_d;
    logic                  slip_q, slip_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic [1:0]            header_q, header_d;
    logic                  header_valid_q, header_valid_d;

    logic                  hdr_qual;
    logic                  hdr_bad;
    logic [ShCntW-1:0]     sh_cnt_inc;
    logic [InvldW-1:0]     sh_invld_inc;

    // 01/10 are legal sync headers; 00/11 are invalid.
    assign hdr_qual     = i_rx_header_valid && i_rx_data_valid;
    assign hdr_bad      = ~(i_rx_header[1] ^ i_rx_header[0]);
    assign sh_cnt_inc   = sh_cnt_q + ShCntW'(1);
    assign sh_invld_inc = sh_invld_cnt_q + {{(InvldW-1){1'b0}}, hdr_bad};

    always_comb begin
        state_d        = state_q;
        sh_cnt_d       = sh_cnt_q;
        sh_invld_cnt_d = sh_invld_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        block_lock_d   = block_lock_q;
        slip_d         = 1'b0;
        data_d         = i_rx_data;
        data_valid_d   = i_rx_data_valid;
        header_d       = i_rx_header;
        header_valid_d = i_rx_header_valid;

        unique case (state_q)
            StResetCnt: begin
                sh_cnt_d       = '0;
                sh_invld_cnt_d = '0;
                state_d        = StTestSh;
            end
            StTestSh: begin
                if (hdr_qual) begin
                    sh_cnt_d       = sh_cnt_inc;
                    sh_invld_cnt_d = sh_invld_inc;
                    // Slip takes precedence over window completion.
                    if (hdr_bad && (!block_lock_q || sh_invld_inc == InvldMax)) begin
                        block_lock_d = 1'b0;
                        slip_d       = 1'b1;
                        wait_cnt_d   = '0;
                        state_d      = StSlipWait;
                    end else if (sh_cnt_inc == ShCntMax) begin
                        state_d = StResetCnt;
                        if (sh_invld_inc == '0) begin
                            block_lock_d = 1'b1;
                        end
                    end
                end
            end
            StSlipWait: begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
                if (wait_cnt_q == WaitLast) begin
                    state_d = StResetCnt;
                end
            end
            default: state_d = StResetCnt;
        endcase
    end

    always_ff @(posedge gty_rx_usr_clk) begin
        if (gty_rx_usr_reset) begin
            state_q        <= StResetCnt;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            wait_cnt_q     <= '0;
            block_lock_q   <= 1'b0;
            slip_q         <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            header_q       <= '0;
            header_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_cnt_q       <= sh_cnt_d;
            sh_invld_cnt_q <= sh_invld_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            block_lock_q   <= block_lock_d;
            slip_q         <= slip_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            header_q       <= header_d;
            header_valid_q <= header_valid_d;
        end
    end

    assign o_rx_data         = data_q;
    assign o_rx_data_valid   = data_valid_q;
    assign o_rx_header       = header_q;
    assign o_rx_header_valid = header_valid_q;
    assign o_rx_gearbox_slip = slip_q;
    assign o_block_lock      = block_lock_q;

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Directed bench for pcs_rx_block_lock: lock acquisition, slip rules, reset and a
// misaligned gearbox model, with pass-through checked on every cycle.
module tb_pcs_rx_block_lock;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rx_data = '0;
    logic        rx_data_valid = 1'b0;
    logic [1:0]  rx_header = '0;
    logic        rx_header_valid = 1'b0;
    logic [31:0] o_rx_data;
    logic        o_rx_data_valid;
    logic [1:0]  o_rx_header;
    logic        o_rx_header_valid;
    logic        o_rx_gearbox_slip;
    logic        o_block_lock;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    int slip_cnt = 0;
    int last_slip = -1;
    int spacing = 0;
    int lock_rise = -1;
    logic prev_lock = 1'b0;
    logic alt = 1'b0;
    int gb_mis = 0;

    pcs_rx_block_lock #(
        .DATA_WIDTH      (32),
        .SH_CNT_MAX      (64),
        .SH_INVLD_MAX    (16),
        .SLIP_WAIT_CYCLES(32)
    ) dut (
        .gty_rx_usr_clk   (clk),
        .gty_rx_usr_reset (rst),
        .i_rx_data        (rx_data),
        .i_rx_data_valid  (rx_data_valid),
        .i_rx_header      (rx_header),
        .i_rx_header_valid(rx_header_valid),
        .o_rx_data        (o_rx_data),
        .o_rx_data_valid  (o_rx_data_valid),
        .o_rx_header      (o_rx_header),
        .o_rx_header_valid(o_rx_header_valid),
        .o_rx_gearbox_slip(o_rx_gearbox_slip),
        .o_block_lock     (o_block_lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, step past the edge, check pass-through and track slip/lock.
    task automatic cyc(input logic dv, input logic hv, input logic [1:0] h);
        logic [31:0] d;
        logic [63:0] exp;
        d = $urandom;
        rx_data = d;
        rx_data_valid = dv;
        rx_header = h;
        rx_header_valid = hv;
        @(posedge clk);
        #1;
        cycle_no++;
        exp = rst ? 64'd0 : {28'd0, d, dv, h, hv};
        chk("passthru", {28'd0, o_rx_data, o_rx_data_valid, o_rx_header, o_rx_header_valid}, exp);
        if (o_rx_gearbox_slip === 1'b1) begin
            slip_cnt++;
            if (last_slip >= 0) begin
                spacing = cycle_no - last_slip;
                chk("slip_min_gap", 64'(spacing >= 34), 64'd1);
            end
            last_slip = cycle_no;
            if (gb_mis > 0) gb_mis--;
        end
        if (o_block_lock === 1'b1 && !prev_lock) lock_rise = cycle_no;
        prev_lock = (o_block_lock === 1'b1);
    endtask

    function automatic logic [1:0] next_valid();
        alt = ~alt;
        return alt ? 2'b01 : 2'b10;
    endfunction

    // One 66b block: header word then second word.
    task automatic blk(input logic [1:0] h);
        cyc(1'b1, 1'b1, h);
        cyc(1'b1, 1'b0, 2'b00);
    endtask

    task automatic valid_blocks(input int n);
        for (int i = 0; i < n; i++) blk(next_valid());
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 2'b11);
        chk({tag, "_lock"}, 64'(o_block_lock), 64'd0);
        chk({tag, "_slip"}, 64'(o_rx_gearbox_slip), 64'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        int s0;
        int q;
        int n;
        logic dv;
        logic hv;

        // Reset state
        rst = 1'b1;
        cyc(1'b0, 1'b0, 2'b00);
        reset_pulse("rst0");

        // 1: 64 valid alternating headers -> lock one cycle after header #64
        s0 = slip_cnt;
        valid_blocks(63);
        chk("t1_lock_63", 64'(o_block_lock), 64'd0);
        cyc(1'b1, 1'b1, next_valid());
        chk("t1_lock_64", 64'(o_block_lock), 64'd1);
        cyc(1'b1, 1'b0, 2'b00);
        chk("t1_no_slip", 64'(slip_cnt - s0), 64'd0);

        // 3: 15 invalid in a window keeps lock; 16 invalid drops lock and slips
        s0 = slip_cnt;
        for (int i = 0; i < 15; i++) blk(2'b11);
        valid_blocks(49);
        chk("t3_lock_15inv", 64'(o_block_lock), 64'd1);
        chk("t3_noslip_15inv", 64'(slip_cnt - s0), 64'd0);
        for (int i = 0; i < 15; i++) blk(2'b00);
        chk("t3_lock_pre16", 64'(o_block_lock), 64'd1);
        cyc(1'b1, 1'b1, 2'b11);
        chk("t3_lock_16inv", 64'(o_block_lock), 64'd0);
        chk("t3_slip_16inv", 64'(o_rx_gearbox_slip), 64'd1);
        cyc(1'b1, 1'b0, 2'b00);
        chk("t3_slip_1cyc", 64'(o_rx_gearbox_slip), 64'd0);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 2'b00);
        chk("t3_single_slip", 64'(slip_cnt - s0), 64'd1);

        // 2: unlocked, invalid header #10 -> immediate 1-cycle slip; counting resumes
        //    on the 17th block after the slip, so lock lands on block 80
        valid_blocks(9);
        cyc(1'b1, 1'b1, 2'b00);
        chk("t2_slip", 64'(o_rx_gearbox_slip), 64'd1);
        chk("t2_lock", 64'(o_block_lock), 64'd0);
        cyc(1'b1, 1'b0, 2'b00);
        chk("t2_slip_1cyc", 64'(o_rx_gearbox_slip), 64'd0);
        valid_blocks(79);
        chk("t2_lock_blk79", 64'(o_block_lock), 64'd0);
        cyc(1'b1, 1'b1, next_valid());
        chk("t2_lock_blk80", 64'(o_block_lock), 64'd1);
        cyc(1'b1, 1'b0, 2'b00);

        // 6a: reset while locked
        reset_pulse("t6_locked");

        // 4: random qualifier gaps; garbage headers on non-qualifying cycles
        q = 0;
        n = 0;
        while (q < 64 && n < 2000) begin
            hv = 1'($urandom_range(0, 1));
            dv = ($urandom_range(0, 3) != 0);
            n++;
            if (hv && dv) begin
                cyc(dv, hv, next_valid());
                q++;
                chk("t4_lock", 64'(o_block_lock), 64'(q == 64));
            end else begin
                cyc(dv, hv, 2'b00);
            end
        end
        chk("t4_count", 64'(q), 64'd64);

        // 5: gearbox model misaligned by 3 slip positions
        reset_pulse("t5_rst");
        s0 = slip_cnt;
        gb_mis = 3;
        lock_rise = -1;
        for (int i = 0; i < 400 && lock_rise < 0; i++) begin
            n = slip_cnt;
            cyc(1'b1, 1'b1, (gb_mis == 0) ? next_valid() : 2'b11);
            if (slip_cnt != n && slip_cnt - s0 > 1) chk("t5_gap", 64'(spacing), 64'd34);
            cyc(1'b1, 1'b0, 2'b00);
        end
        chk("t5_slips", 64'(slip_cnt - s0), 64'd3);
        chk("t5_lock", 64'(o_block_lock), 64'd1);
        chk("t5_lock_delay", 64'(lock_rise - last_slip), 64'd160);

        // 6b: reset during SLIP_WAIT, then relock after exactly 64 headers
        for (int i = 0; i < 15; i++) blk(2'b11);
        cyc(1'b1, 1'b1, 2'b11);
        chk("t6_slip", 64'(o_rx_gearbox_slip), 64'd1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'b00);
        reset_pulse("t6_slipwait");
        valid_blocks(63);
        chk("t6_relock_63", 64'(o_block_lock), 64'd0);
        cyc(1'b1, 1'b1, next_valid());
        chk("t6_relock_64", 64'(o_block_lock), 64'd1);
        cyc(1'b1, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
